// File: rtl/dctc_pkg.sv
// Shared types and default constants for the DCTC multi-channel distance detector.
package dctc_pkg;

    localparam int DEF_NUM_CH    = 8;
    localparam int DEF_SAMPLE_W  = 18;
    localparam int DEF_FEAT_W    = 17;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_BASE_ADDR = 18;
    localparam int DEF_ACC_W     = 20;

    // 10.0 in Q8.12
    localparam logic [DEF_ACC_W-1:0] DEF_THRESHOLD = 20'h0A000;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        CAP,
        DIST,
        DECIDE
    } state_t;

    // A required run length of zero is treated as one window.
    function automatic logic [3:0] consec_floor(input logic [3:0] n);
        return (n == 4'd0) ? 4'd1 : n;
    endfunction

endpackage

// File: rtl/dctc_mc_if.sv
// FIFO read port: address and strobe out, sample back one cycle after the strobe.
interface dctc_mc_if
    import dctc_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SAMPLE_W = DEF_SAMPLE_W
);
    logic [ADDR_W-1:0]   fifo_addr;
    logic                fifo_read;
    logic [SAMPLE_W-1:0] fifo_sample;

    modport master (output fifo_addr, output fifo_read, input fifo_sample);
    modport slave  (input fifo_addr, input fifo_read, output fifo_sample);
endinterface

// File: rtl/dctc_consec_cnt.sv
// Saturating count of consecutive exceeding windows and the alarm compare.
module dctc_consec_cnt
    import dctc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic       exceed,
    input  logic [3:0] consec_n,
    output logic       alarm
);
    logic [3:0] hit_cnt;
    logic [3:0] hit_next;
    logic [3:0] need;

    // Next hit count: saturating increment on exceed, clear otherwise.
    always_comb begin
        hit_next = hit_cnt;
        need     = consec_floor(consec_n);
        if (exceed) begin
            if (hit_cnt != 4'hF) begin
                hit_next = hit_cnt + 4'd1;
            end
        end else begin
            hit_next = 4'd0;
        end
    end

    // Counter and alarm change only on a window decision; they hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt <= 4'd0;
            alarm   <= 1'b0;
        end else if (update) begin
            hit_cnt <= hit_next;
            alarm   <= (hit_next >= need);
        end
    end

endmodule

// File: rtl/dctc_mc.sv
// Window controller: reads one FIFO sample per channel, accumulates live and
// reference sums, and reports their absolute difference and an alarm level.
//
// state  | meaning
// IDLE   | waiting for start; snapshot reference on start
// ADDR   | present FIFO address for current channel
// READ   | one-cycle FIFO read strobe
// CAP    | accumulate returned sample and reference sample
// DIST   | latch |sum - ref_sum|
// DECIDE | update hit counter and alarm, finish pulse follows
module dctc_mc
    import dctc_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int FEAT_W    = DEF_FEAT_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int ACC_W     = FEAT_W + $clog2(NUM_CH)
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_CH*SAMPLE_W-1:0] ref_samples,
    input  logic [ACC_W-1:0]           threshold,
    input  logic [3:0]                 consec_n,
    dctc_mc_if.master                  fifo,
    output logic [ACC_W-1:0]           distance,
    output logic                       dctc_finish,
    output logic                       seizure_prediction
);
    localparam int CH_W = $clog2(NUM_CH);

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   ch;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  ref_sum;
    logic [FEAT_W-1:0] snap [NUM_CH];
    logic              read_strb;
    logic              last_ch;

    assign last_ch        = (ch == CH_W'(NUM_CH - 1));
    assign fifo.fifo_read = read_strb;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and read strobe decode.
    always_comb begin
        state_next = state;
        read_strb  = 1'b0;
        unique case (state)
            IDLE:    if (start) state_next = ADDR;
            ADDR:    state_next = READ;
            READ: begin
                read_strb  = 1'b1;
                state_next = CAP;
            end
            CAP:     state_next = last_ch ? DIST : ADDR;
            DIST:    state_next = DECIDE;
            DECIDE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: snapshot, channel index, accumulators, address and distance.
    // Only the feature bits of each reference sample are kept in the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch             <= '0;
            sum            <= '0;
            ref_sum        <= '0;
            fifo.fifo_addr <= '0;
            distance       <= '0;
            dctc_finish    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i] <= '0;
            end
        end else begin
            dctc_finish <= (state == DECIDE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ch      <= '0;
                        sum     <= '0;
                        ref_sum <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap[i] <= ref_samples[i*SAMPLE_W +: FEAT_W];
                        end
                    end
                end
                ADDR: fifo.fifo_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(ch);
                CAP: begin
                    sum     <= sum + ACC_W'(fifo.fifo_sample[FEAT_W-1:0]);
                    ref_sum <= ref_sum + ACC_W'(snap[ch]);
                    if (!last_ch) begin
                        ch <= ch + CH_W'(1);
                    end
                end
                DIST: distance <= (sum >= ref_sum) ? (sum - ref_sum) : (ref_sum - sum);
                default: ;
            endcase
        end
    end

    // Sample bits above the feature width are deliberately ignored.
    generate
        if (FEAT_W < SAMPLE_W) begin : g_hi_bits
            logic unused_hi;
            always_comb begin
                unused_hi = ^fifo.fifo_sample[SAMPLE_W-1:FEAT_W];
                for (int i = 0; i < NUM_CH; i++) begin
                    unused_hi = unused_hi ^ (^ref_samples[i*SAMPLE_W+FEAT_W +: SAMPLE_W-FEAT_W]);
                end
            end
        end
    endgenerate

    dctc_consec_cnt u_consec (
        .clk      (clk),
        .reset    (reset),
        .update   (state == DECIDE),
        .exceed   (distance > threshold),
        .consec_n (consec_n),
        .alarm    (seizure_prediction)
    );

endmodule

// File: tb/tb_dctc_mc.sv
// Self-checking bench for dctc_mc: directed spec vectors plus random windows
// checked against a window-level reference model.
module tb_dctc_mc;
    import dctc_pkg::*;

    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 18;
    localparam int FEAT_W   = 17;
    localparam int ADDR_W   = 8;
    localparam int BASE     = 18;
    localparam int ACC_W    = 20;
    localparam int LAT      = 3 * NUM_CH + 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [NUM_CH*SAMPLE_W-1:0] ref_samples;
    logic [ACC_W-1:0]           threshold;
    logic [3:0]                 consec_n;
    logic [ACC_W-1:0]           distance;
    logic                       dctc_finish;
    logic                       seizure_prediction;

    dctc_mc_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) fif ();

    dctc_mc dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .ref_samples        (ref_samples),
        .threshold          (threshold),
        .consec_n           (consec_n),
        .fifo               (fif),
        .distance           (distance),
        .dctc_finish        (dctc_finish),
        .seizure_prediction (seizure_prediction)
    );

    always #5 clk = ~clk;

    logic [SAMPLE_W-1:0] mem      [256];
    logic [SAMPLE_W-1:0] ref_vals [NUM_CH];
    logic [ADDR_W-1:0]   read_q   [$];

    int         errors = 0;
    int         checks = 0;
    int         hits = 0;
    logic       exp_pred = 1'b0;
    logic [ACC_W-1:0] exp_dist = '0;

    // FIFO model: data returned the cycle after the read strobe.
    always @(posedge clk) begin
        if (fif.fifo_read) begin
            fif.fifo_sample <= mem[fif.fifo_addr];
            read_q.push_back(fif.fifo_addr);
        end
    end

    task automatic apply_ref();
        for (int i = 0; i < NUM_CH; i++) ref_samples[i*SAMPLE_W +: SAMPLE_W] = ref_vals[i];
    endtask

    task automatic fill(input logic [SAMPLE_W-1:0] fv, input logic [SAMPLE_W-1:0] rv);
        for (int i = 0; i < NUM_CH; i++) begin
            mem[BASE+i] = fv;
            ref_vals[i] = rv;
        end
        apply_ref();
    endtask

    function automatic logic [ACC_W-1:0] model_distance();
        int s = 0;
        int r = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            s += int'(mem[BASE+i] & 18'h1FFFF);
            r += int'(ref_vals[i] & 18'h1FFFF);
        end
        return ACC_W'((s > r) ? s - r : r - s);
    endfunction

    task automatic model_decide();
        int need;
        exp_dist = model_distance();
        if (exp_dist > threshold) hits = (hits < 15) ? hits + 1 : 15;
        else hits = 0;
        need = (consec_n == 4'd0) ? 1 : int'(consec_n);
        exp_pred = (hits >= need);
    endtask

    // Starts a window at the next edge; returns at the negedge where finish is seen.
    task automatic run_window(output int lat);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (dctc_finish) break;
        end
    endtask

    task automatic check_window(input string name, input int lat);
        model_decide();
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        end
        checks++;
        if (distance !== exp_dist) begin
            errors++;
            $display("FAIL %s distance: got %h expected %h", name, distance, exp_dist);
        end
        checks++;
        if (seizure_prediction !== exp_pred) begin
            errors++;
            $display("FAIL %s prediction: got %b expected %b", name, seizure_prediction, exp_pred);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({distance, seizure_prediction, dctc_finish, fif.fifo_read, fif.fifo_addr} !== '0) begin
            errors++;
            $display("FAIL %s outputs: dist=%h pred=%b fin=%b rd=%b addr=%h expected all 0",
                     name, distance, seizure_prediction, dctc_finish, fif.fifo_read, fif.fifo_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        threshold = DEF_THRESHOLD;
        consec_n = 4'd1;
        fill('0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        fill(18'h01000, '0);
        consec_n = 4'd1;
        run_window(lat);
        check_window("basic", lat);
        checks++;
        if (distance !== 20'h08000) begin
            errors++;
            $display("FAIL basic_const distance: got %h expected 08000", distance);
        end
    endtask

    task automatic test_consec();
        int lat;
        fill(18'h02000, '0);
        consec_n = 4'd2;
        run_window(lat);
        check_window("consec_w1", lat);
        run_window(lat);
        check_window("consec_w2", lat);
        checks++;
        if (seizure_prediction !== 1'b1) begin
            errors++;
            $display("FAIL consec_alarm prediction: got %b expected 1", seizure_prediction);
        end
    endtask

    task automatic test_threshold_equal();
        int lat;
        fill(18'h01400, '0);
        consec_n = 4'd1;
        run_window(lat);
        check_window("thr_equal", lat);
    endtask

    task automatic test_mask_snapshot();
        int lat;
        fill(18'h21000, 18'h00800);
        fork
            run_window(lat);
            begin
                repeat (8) @(negedge clk);
                ref_samples = '1;
            end
        join
        check_window("mask_snapshot", lat);
        apply_ref();
    endtask

    task automatic test_reset_mid();
        int lat;
        int fin = 0;
        fill(18'h02000, '0);
        consec_n = 4'd1;
        run_window(lat);
        check_window("pre_reset", lat);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        hits = 0;
        check_all_zero("reset_mid");
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (dctc_finish) fin++;
        end
        checks++;
        if (fin !== 0) begin
            errors++;
            $display("FAIL reset_abort finishes: got %0d expected 0", fin);
        end
        run_window(lat);
        check_window("post_reset", lat);
    endtask

    task automatic test_start_ignored();
        int fin = 0;
        fill(18'h01000, '0);
        read_q.delete();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int lat = 1; lat <= 45; lat++) begin
            @(posedge clk);
            @(negedge clk);
            if (dctc_finish) fin++;
            start = (lat == 5 || lat == 20);
        end
        start = 1'b0;
        model_decide();
        checks++;
        if (fin !== 1) begin
            errors++;
            $display("FAIL start_ignored finishes: got %0d expected 1", fin);
        end
        checks++;
        if (read_q.size() !== NUM_CH) begin
            errors++;
            $display("FAIL start_ignored reads: got %0d expected %0d", read_q.size(), NUM_CH);
        end
        for (int i = 0; i < read_q.size(); i++) begin
            checks++;
            if (read_q[i] !== ADDR_W'(BASE + i)) begin
                errors++;
                $display("FAIL read_addr[%0d]: got %0d expected %0d", i, read_q[i], BASE + i);
            end
        end
        checks++;
        if (distance !== exp_dist) begin
            errors++;
            $display("FAIL start_ignored distance: got %h expected %h", distance, exp_dist);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem[BASE+i] = SAMPLE_W'($urandom_range(0, 18'h3FFFF));
                ref_vals[i] = SAMPLE_W'($urandom_range(0, 18'h3FFFF));
            end
            apply_ref();
            threshold = ACC_W'($urandom_range(0, 20'h60000));
            consec_n = 4'($urandom_range(0, 3));
            run_window(lat);
            check_window($sformatf("random%0d", n), lat);
        end
        threshold = DEF_THRESHOLD;
    endtask

    task automatic test_back_to_back();
        int lat;
        consec_n = 4'd1;
        fill(18'h02000, '0);
        run_window(lat);
        check_window("b2b_w1", lat);
        fill(18'h01000, '0);
        run_window(lat);
        check_window("b2b_w2", lat);
        fill(18'h00400, 18'h03000);
        run_window(lat);
        check_window("b2b_w3", lat);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_consec();
        test_threshold_equal();
        test_mask_snapshot();
        test_reset_mid();
        test_start_ignored();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dctc_mc.md
DCTC_MC -- requirements
Module: dctc_mc

Interface
REQ-001 Parameter NUM_CH, default 8: number of channels per window, range 2..32.
REQ-002 Parameter SAMPLE_W, default 18: FIFO and reference sample width.
REQ-003 Parameter FEAT_W, default 17: low magnitude bits used per sample; bits above are ignored.
REQ-004 Parameter ADDR_W, default 8; parameter BASE_ADDR, default 18: FIFO address of channel 0.
REQ-005 Derived ACC_W = FEAT_W + clog2(NUM_CH), 20 at defaults (Q8.12).
REQ-006 The module SHALL have one clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port reset, input, 1: synchronous active-high reset.
REQ-009 Port start, input, 1: single-cycle window request.
REQ-010 Port ref_samples, input, NUM_CH*SAMPLE_W: model samples, channel 0 in the LSBs.
REQ-011 Port threshold, input, ACC_W: distance limit.
REQ-012 Port consec_n, input, 4: consecutive exceeding windows required for an alarm.
REQ-013 Port fifo_addr, output, ADDR_W: FIFO read address.
REQ-014 Port fifo_read, output, 1: FIFO read strobe.
REQ-015 Port fifo_sample, input, SAMPLE_W: FIFO data, valid the cycle after fifo_read.
REQ-016 Port distance, output, ACC_W: last computed absolute distance.
REQ-017 Port dctc_finish, output, 1: one-cycle window-complete pulse.
REQ-018 Port seizure_prediction, output, 1: alarm level.

Function
REQ-019 FSM states are IDLE, ADDR, READ, CAP, DIST and DECIDE.
REQ-020 IDLE with start=1: snapshot ref_samples, clear sum, ref_sum and ch, then go to ADDR; start outside IDLE is ignored.
REQ-021 ADDR: fifo_addr = BASE_ADDR + ch, then go to READ.
REQ-022 READ: fifo_read = 1 for exactly this cycle, then go to CAP.
REQ-023 CAP: sum += fifo_sample[FEAT_W-1:0] and ref_sum += snapshot[ch][FEAT_W-1:0]; then go to ADDR with ch+1, or to DIST when ch = NUM_CH-1.
REQ-024 DIST: distance <= |sum - ref_sum|, which is 0 when the two are equal; then go to DECIDE.
REQ-025 DECIDE: strictly distance > threshold increments a saturating 4-bit hit counter; otherwise the counter clears.
REQ-026 DECIDE: seizure_prediction <= (hit counter after update >= max(consec_n, 1)); consec_n = 0 behaves as 1.
REQ-027 DECIDE: dctc_finish is high for exactly the next cycle, and the FSM returns to IDLE.
REQ-028 Latency: dctc_finish is high 3*NUM_CH+2 cycles after the clock edge that samples start (26 cycles at defaults).
REQ-029 seizure_prediction and distance hold their values between decisions.
REQ-030 fifo_addr holds its last value while idle.
REQ-031 Accumulators are ACC_W bits wide and cannot overflow; no saturation logic is required.
REQ-032 A start in the cycle dctc_finish is high is accepted, giving back-to-back windows with 3*NUM_CH+3 cycles per window.

Reset
REQ-033 reset=1 SHALL force state IDLE and clear sum, ref_sum, ch, the hit counter and the snapshot.
REQ-034 reset=1 SHALL clear fifo_addr, fifo_read, distance, dctc_finish and seizure_prediction to 0.
REQ-035 Reset mid-window SHALL abort the window with no dctc_finish, and takes priority over start in the same cycle.

Structure
REQ-036 Package dctc_pkg SHALL hold the state enum, the default parameter constants and the default threshold constant 20'h0A000 (10.0 in Q8.12).
REQ-037 Sub-module dctc_consec_cnt SHALL contain the saturating hit counter and the alarm compare.
REQ-038 Target size: 120-400 RTL lines.

Verification (defaults, threshold=20'h0A000)
REQ-039 All fifo_sample=18'h01000, ref=0, consec_n=1 -> distance=20'h08000, prediction=0, finish at cycle 26.
REQ-040 All fifo_sample=18'h02000, ref=0, consec_n=2 -> distance=20'h10000 both windows; prediction 0 after window 1 and 1 after window 2.
REQ-041 Distance exactly 20'h0A000 (fifo=18'h01400, ref=0) following an alarm -> counter clears, prediction=0.
REQ-042 fifo_sample=18'h21000 (bit 17 set) -> treated as 18'h01000; ref changed mid-window -> result uses the snapshot value.
REQ-043 Reset asserted at cycle 10 -> all outputs 0 next cycle, no finish; a new start then completes normally in 26 cycles.
REQ-044 start pulsed at cycles 5 and 20 of a window -> ignored, exactly one finish; fifo_read pulses 8 times, at addresses 18..25.
